// File: rtl/clk_div_ctrl.sv
// Sequencer for the shared clock divider: runs it for a requested number of div_clk toggles, then guards in IDLE mode.
// Registered outputs, one cycle after the deciding edge; req_ready is low for the whole run, so requests wait.
module clk_div_ctrl #(
  parameter int CNT_W        = 16,
  parameter int GUARD_CYCLES = 2,
  parameter int WDOG_W       = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [CNT_W-1:0] req_toggles,
  input  logic             abort,
  input  logic             div_clk,
  output logic [1:0]       div_mod,
  output logic             div_rst,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             timeout,
  output logic             err,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, STOP} state_t;

  state_t            state, state_nxt;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  target;
  logic [CNT_W:0]    cnt_inc;
  logic [WDOG_W-1:0] wdog, wdog_inc;
  logic [GW-1:0]     guard_cnt;
  logic              div_clk_q, div_edge;
  logic              accept, mode_ok, req_zero, hit, wdog_exp;
  logic              req_ready_nxt, busy_nxt, div_rst_nxt, done_nxt, err_nxt;
  logic [1:0]        div_mod_nxt;

  assign accept   = req_valid & req_ready;
  assign mode_ok  = (req_mode == 2'd1) || (req_mode == 2'd2);
  assign req_zero = (req_toggles == '0);
  assign div_edge = div_clk ^ div_clk_q;
  // Extra bit so an all-ones target compares without wrapping.
  assign cnt_inc  = {1'b0, toggle_cnt} + (CNT_W+1)'(1);
  assign hit      = div_edge && (cnt_inc == {1'b0, target});
  assign wdog_inc = (&wdog) ? wdog : wdog + WDOG_W'(1);
  assign wdog_exp = !div_edge && (&wdog_inc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      div_mod   <= 2'd0;
      div_rst   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_ready <= req_ready_nxt;
      div_mod   <= div_mod_nxt;
      div_rst   <= div_rst_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && mode_ok && !req_zero) state_nxt = START;
      START:   state_nxt = abort ? STOP : RUN;
      RUN:     if (hit || abort || wdog_exp) state_nxt = STOP;
      STOP:    if (guard_cnt == GUARD_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they line up with the state register.
  always_comb begin
    req_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
    div_rst_nxt   = (state_nxt == START);
    div_mod_nxt   = 2'd0;
    if (state_nxt == START) div_mod_nxt = req_mode;
    else if (state_nxt == RUN) div_mod_nxt = mode_q;
    done_nxt = ((state == STOP) && (state_nxt == IDLE)) ||
               ((state == IDLE) && accept && mode_ok && req_zero);
    err_nxt  = (state == IDLE) && accept && !mode_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q     <= 2'd0;
      target     <= '0;
      toggle_cnt <= '0;
      aborted    <= 1'b0;
      timeout    <= 1'b0;
      wdog       <= '0;
      guard_cnt  <= '0;
      div_clk_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && mode_ok) begin
            mode_q     <= req_mode;
            target     <= req_toggles;
            toggle_cnt <= '0;
            aborted    <= 1'b0;
            timeout    <= 1'b0;
            wdog       <= '0;
          end
        end
        START: begin
          div_clk_q <= 1'b0;
          guard_cnt <= '0;
          if (abort) aborted <= 1'b1;
        end
        RUN: begin
          div_clk_q <= div_clk;
          guard_cnt <= '0;
          if (div_edge) begin
            toggle_cnt <= cnt_inc[CNT_W-1:0];
            wdog       <= '0;
          end else begin
            wdog <= wdog_inc;
          end
          // Completion outranks abort, abort outranks the watchdog.
          if (!hit) begin
            if (abort) aborted <= 1'b1;
            else if (wdog_exp) timeout <= 1'b1;
          end
        end
        STOP:    guard_cnt <= guard_cnt + GW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed and random runs against an edge-list reference model.
module tb_clk_div_ctrl;

  localparam int CNT_W  = 6;
  localparam int G      = 2;
  localparam int WDOG_W = 4;
  localparam int WD_LIM = (1 << WDOG_W) - 1;
  localparam int MAXS   = 250;
  localparam int NONE   = 1000000;

  typedef int iq_t[$];

  logic             clk = 1'b0;
  logic             rst, req_valid, req_ready, abort, div_clk;
  logic             div_rst, busy, done, aborted, timeout, err;
  logic [1:0]       req_mode, div_mod;
  logic [CNT_W-1:0] req_toggles, toggle_cnt;

  int checks = 0;
  int errors = 0;

  // One entry per sample taken 1 time unit after each clk edge, starting at the accept edge.
  logic [1:0]       tr_mod   [MAXS];
  logic             tr_rst   [MAXS];
  logic             tr_busy  [MAXS];
  logic             tr_done  [MAXS];
  logic             tr_ready [MAXS];
  int               done_at, err_seen;
  logic [CNT_W-1:0] end_cnt;
  logic             end_ab, end_to, start_ab, start_to;
  int               last_cnt;
  bit               last_ab, last_to;

  clk_div_ctrl #(.CNT_W(CNT_W), .GUARD_CYCLES(G), .WDOG_W(WDOG_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_toggles(req_toggles), .abort(abort), .div_clk(div_clk),
    .div_mod(div_mod), .div_rst(div_rst), .busy(busy), .done(done), .aborted(aborted),
    .timeout(timeout), .err(err), .toggle_cnt(toggle_cnt)
  );

  always #5 clk = ~clk;

  // Edge and abort times are RUN-cycle numbers (1 = first RUN cycle, abort at 0 = during START).
  function automatic void model(input int tgt, input int abort_at, input iq_t edges,
                                output int e_end, output int cnt, output bit ab, output bit to);
    int ec, et, prev;
    ec = (edges.size() >= tgt) ? edges[tgt-1] : NONE;
    et = NONE;
    prev = 0;
    foreach (edges[i]) begin
      if (et == NONE && edges[i] - prev > WD_LIM) et = prev + WD_LIM;
      prev = edges[i];
    end
    if (et == NONE) et = prev + WD_LIM;
    ab = 0;
    to = 0;
    if (abort_at == 0) begin
      e_end = 0;
      ab = 1;
    end else begin
      e_end = ec;
      if (abort_at > 0 && abort_at < e_end) begin e_end = abort_at; ab = 1; end
      if (et < e_end) begin e_end = et; ab = 0; to = 1; end
    end
    cnt = 0;
    foreach (edges[i]) if (edges[i] <= e_end) cnt++;
  endfunction

  // Issues one request and plays the div_clk/abort schedule until done or the cycle budget runs out.
  task automatic drive_run(input logic [1:0] mode, input int tgt, input iq_t edges,
                           input int abort_at, input bit pester);
    int   ei;
    logic lvl;
    req_mode = mode; req_toggles = CNT_W'(tgt); req_valid = 1'b1; abort = 1'b0; div_clk = 1'b0;
    lvl = 1'b0; ei = 0; done_at = -1; err_seen = 0;
    @(posedge clk); #1;
    req_valid = pester;
    req_mode  = 2'd3;
    start_ab  = aborted;
    start_to  = timeout;
    for (int s = 0; s < MAXS; s++) begin
      if (s > 0) begin @(posedge clk); #1; end
      tr_mod[s] = div_mod; tr_rst[s] = div_rst; tr_busy[s] = busy;
      tr_done[s] = done; tr_ready[s] = req_ready;
      if (err) err_seen++;
      if (done) begin
        done_at = s; end_cnt = toggle_cnt; end_ab = aborted; end_to = timeout;
        break;
      end
      abort = (s == abort_at);
      if (s > 0 && ei < edges.size() && edges[ei] == s) begin lvl = ~lvl; ei++; end
      div_clk = lvl;
    end
    req_valid = 1'b0; abort = 1'b0; div_clk = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; abort = 1'b0; div_clk = 1'b0; req_mode = 2'd0; req_toggles = '0;
    #1 rst = 1'b1;
    #12;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    checks++; if (div_mod !== 2'd0) begin errors++; $display("FAIL reset_mod: got %0d expected 0", div_mod); end
    checks++; if (div_rst !== 1'b1) begin errors++; $display("FAIL reset_div_rst: got %b expected 1", div_rst); end
    checks++; if ({busy, done, aborted, timeout, err} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {busy, done, aborted, timeout, err}); end
    checks++; if (toggle_cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", toggle_cnt); end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (div_rst !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: got div_rst=%b ready=%b busy=%b expected 0 1 0", div_rst, req_ready, busy); end
  endtask

  task automatic test_runs();
    iq_t        edges;
    int         tgt, ab_at, e_end, cnt, bad, t, gap;
    bit         ab, to, pester;
    logic [1:0] mode;
    for (int i = 0; i < 28; i++) begin
      edges = {}; ab_at = -1; pester = 0; mode = 2'd1;
      case (i)
        0: begin tgt = 4;  for (int k = 1; k <= 6; k++) edges.push_back(3*k); end
        1: begin mode = 2'd2; tgt = 10; for (int k = 1; k <= 12; k++) edges.push_back(3*k); ab_at = 7; end
        2: begin tgt = 10; for (int k = 1; k <= 12; k++) edges.push_back(2*k); ab_at = 20; end
        3: begin tgt = 5;  for (int k = 1; k <= 6; k++) edges.push_back(2*k); ab_at = 0; end
        4: begin tgt = 5; end
        5: begin mode = 2'd2; tgt = 63; for (int k = 1; k <= 66; k++) edges.push_back(k); end
        6: begin tgt = 8; edges = '{2, 4, 20, 22}; end
        7: begin mode = 2'd2; tgt = 3; edges = '{2, 17, 19}; pester = 1; end
        default: begin
          mode = 2'($urandom_range(1, 2));
          tgt = $urandom_range(1, 12);
          t = 0;
          for (int k = 0; k < tgt + 3; k++) begin
            gap = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 17) : $urandom_range(1, 5);
            t += gap;
            edges.push_back(t);
          end
          if ($urandom_range(0, 2) == 0) ab_at = $urandom_range(0, t);
          pester = i[0];
        end
      endcase
      model(tgt, ab_at, edges, e_end, cnt, ab, to);
      drive_run(mode, tgt, edges, ab_at, pester);
      checks++; if (done_at != e_end + G + 1) begin
        errors++; $display("FAIL run%0d done_cycle: got %0d expected %0d", i, done_at, e_end + G + 1); end
      bad = 0;
      if (done_at >= 0)
        for (int s = 0; s <= done_at; s++)
          if (tr_busy[s] !== (s <= e_end + G) || tr_ready[s] !== (s > e_end + G) ||
              tr_done[s] !== (s == e_end + G + 1) || tr_rst[s] !== (s == 0) ||
              tr_mod[s] !== ((s <= e_end) ? mode : 2'd0)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL run%0d trace: %0d bad cycles, expected 0", i, bad); end
      checks++; if (end_cnt !== CNT_W'(cnt)) begin
        errors++; $display("FAIL run%0d toggle_cnt: got %0d expected %0d", i, end_cnt, cnt); end
      checks++; if (end_ab !== ab || end_to !== to) begin
        errors++; $display("FAIL run%0d status: got aborted=%b timeout=%b expected %b %b", i, end_ab, end_to, ab, to); end
      checks++; if (start_ab !== 1'b0 || start_to !== 1'b0) begin
        errors++; $display("FAIL run%0d accept_clears: got aborted=%b timeout=%b expected 0 0", i, start_ab, start_to); end
      checks++; if (err_seen != 0) begin errors++; $display("FAIL run%0d err_while_busy: got %0d expected 0", i, err_seen); end
      last_cnt = cnt; last_ab = ab; last_to = to;
    end
  endtask

  task automatic test_reject();
    logic [1:0] bad_modes [2];
    bad_modes[0] = 2'd3;
    bad_modes[1] = 2'd0;
    foreach (bad_modes[m]) begin
      req_mode = bad_modes[m]; req_toggles = CNT_W'(5); req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL reject%0d err: got %b expected 1", m, err); end
      checks++; if (busy !== 1'b0 || div_mod !== 2'd0 || div_rst !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL reject%0d outputs: got busy=%b mod=%0d div_rst=%b done=%b expected 0 0 0 0", m, busy, div_mod, div_rst, done); end
      checks++; if (toggle_cnt !== CNT_W'(last_cnt) || aborted !== last_ab || timeout !== last_to) begin
        errors++; $display("FAIL reject%0d state_kept: got cnt=%0d ab=%b to=%b expected %0d %b %b", m, toggle_cnt, aborted, timeout, last_cnt, last_ab, last_to); end
      @(posedge clk); #1;
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reject%0d pulse: got err=%b busy=%b expected 0 0", m, err, busy); end
    end
  endtask

  task automatic test_zero();
    req_mode = 2'd2; req_toggles = '0; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || div_rst !== 1'b0 || div_mod !== 2'd0) begin
      errors++; $display("FAIL zero_done: got done=%b busy=%b div_rst=%b mod=%0d expected 1 0 0 0", done, busy, div_rst, div_mod); end
    checks++; if (toggle_cnt !== '0 || aborted !== 1'b0 || timeout !== 1'b0) begin
      errors++; $display("FAIL zero_clear: got cnt=%0d ab=%b to=%b expected 0 0 0", toggle_cnt, aborted, timeout); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || div_rst !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_after: got done=%b div_rst=%b busy=%b expected 0 0 0", done, div_rst, busy); end
  endtask

  task automatic test_reset_mid_run();
    iq_t edges;
    req_mode = 2'd1; req_toggles = CNT_W'(20); req_valid = 1'b1; div_clk = 1'b0;
    @(posedge clk); #1 req_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k[0]) div_clk = ~div_clk;
    end
    #3 rst = 1'b1;
    #1;
    checks++; if (div_mod !== 2'd0 || div_rst !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL async_reset: got mod=%0d div_rst=%b busy=%b ready=%b expected 0 1 0 1", div_mod, div_rst, busy, req_ready); end
    checks++; if (toggle_cnt !== '0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset_cnt: got cnt=%0d done=%b expected 0 0", toggle_cnt, done); end
    div_clk = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    edges = '{2};
    drive_run(2'd1, 1, edges, -1, 1'b0);
    checks++; if (done_at != 2 + G + 1 || end_cnt !== CNT_W'(1)) begin
      errors++; $display("FAIL after_reset_run: got done_at=%0d cnt=%0d expected %0d 1", done_at, end_cnt, 2 + G + 1); end
  endtask

  initial begin
    test_reset();
    test_runs();
    test_reject();
    test_zero();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
